// File: rtl/ysyx_22050133_lsu_pkg.sv
// Shared encodings for the load/store unit: memory op, access size and FSM state.
package ysyx_22050133_lsu_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Reserved encoding behaves like a non-memory op.
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/ysyx_22050133_lsu_align.sv
// Byte-lane steering for the LSU: store strobe/data shifting, load extraction and
// sign/zero extension, and the natural-alignment check. Purely combinational.
module ysyx_22050133_lsu_align
    import ysyx_22050133_lsu_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wstrb_o,
    output logic [63:0] wdata_o,
    output logic [63:0] ldata_o,
    output logic        misalign_o
);

    logic [5:0]  shamt;
    logic [63:0] sh;
    logic [7:0]  base_strb;

    always_comb begin
        shamt      = {off_i, 3'b000};
        sh         = rdata_i >> shamt;
        wdata_o    = wdata_i << shamt;
        base_strb  = 8'h00;
        ldata_o    = 64'd0;
        misalign_o = 1'b0;
        case (size_e'(size_i))
            SZ_B: begin
                base_strb = 8'h01;
                ldata_o   = unsigned_i ? {56'd0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                base_strb  = 8'h03;
                misalign_o = off_i[0];
                ldata_o    = unsigned_i ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            end
            SZ_W: begin
                base_strb  = 8'h0F;
                misalign_o = |off_i[1:0];
                ldata_o    = unsigned_i ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            end
            SZ_D: begin
                base_strb  = 8'hFF;
                misalign_o = |off_i;
                ldata_o    = sh;
            end
        endcase
        wstrb_o = base_strb << off_i;
    end

endmodule

// File: rtl/ysyx_22050133_lsu.sv
// Memory-access stage: one aligned load/store at a time over a valid/ready request
// and response port; non-memory ops pass the execute result through in the same cycle.
module ysyx_22050133_lsu
    import ysyx_22050133_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [1:0]  mem_op_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o,
    output logic        misalign_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        req_wen_o,
    output logic [31:0] req_addr_o,
    output logic [63:0] req_wdata_o,
    output logic [7:0]  req_wstrb_o,
    input  logic        resp_valid_i,
    input  logic [63:0] resp_rdata_i
);

    lsu_state_e  state_q;
    mem_op_e     op_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [63:0] result_q;
    logic        misalign_q;

    logic        idle;
    logic        accept_mem;
    logic        pass_thru;
    logic        is_store;

    logic [2:0]  al_off;
    logic [1:0]  al_size;
    logic        al_unsigned;
    logic [63:0] al_wdata_in;
    logic [7:0]  al_wstrb;
    logic [63:0] al_wdata;
    logic [63:0] al_ldata;
    logic        al_misalign;

    assign idle       = (state_q == ST_IDLE);
    assign accept_mem = idle && valid_i && is_mem_op(mem_op_i);
    assign pass_thru  = idle && valid_i && !is_mem_op(mem_op_i);
    assign is_store   = (op_q == MEM_STORE);

    // In IDLE the aligner only judges alignment of the incoming op; once an access
    // is latched it steers lanes from the held copy so req_* stay stable.
    assign al_off      = idle ? addr_i[2:0] : addr_q[2:0];
    assign al_size     = idle ? size_i      : size_q;
    assign al_unsigned = idle ? unsigned_i  : unsigned_q;
    assign al_wdata_in = idle ? wdata_i     : wdata_q;

    ysyx_22050133_lsu_align u_align (
        .off_i      (al_off),
        .size_i     (al_size),
        .unsigned_i (al_unsigned),
        .wdata_i    (al_wdata_in),
        .rdata_i    (resp_rdata_i),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .ldata_o    (al_ldata),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= MEM_NONE;
            addr_q     <= 32'd0;
            wdata_q    <= 64'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            result_q   <= 64'd0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_mem) begin
                        op_q       <= mem_op_e'(mem_op_i);
                        addr_q     <= addr_i[31:0];
                        wdata_q    <= wdata_i;
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                        misalign_q <= al_misalign;
                        result_q   <= 64'd0;
                        state_q    <= al_misalign ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_ready_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_valid_i) begin
                        result_q <= (op_q == MEM_LOAD) ? al_ldata : 64'd0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = !idle || accept_mem;
    assign done_o      = (state_q == ST_DONE) || pass_thru;
    assign misalign_o  = (state_q == ST_DONE) && misalign_q;
    assign result_o    = pass_thru ? addr_i : result_q;

    assign req_valid_o = (state_q == ST_REQ);
    assign req_wen_o   = is_store;
    assign req_addr_o  = {addr_q[31:3], 3'b000};
    assign req_wstrb_o = (req_valid_o && is_store) ? al_wstrb : 8'h00;
    assign req_wdata_o = (req_valid_o && is_store) ? al_wdata : 64'd0;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Scoreboard bench for the LSU: directed cases plus randomized ops against a
// byte-level reference model, with a memory responder that injects stalls.
module tb_ysyx_22050133_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [1:0]  mem_op_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic        misalign_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_wen_o;
    logic [31:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        resp_valid_i;
    logic [63:0] resp_rdata_i;

    ysyx_22050133_lsu dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
        .done_o(done_o), .result_o(result_o), .misalign_o(misalign_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_wen_o(req_wen_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o),
        .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] res;
        logic        mis;
        logic        bsy;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [7:0]  strb;
        logic [63:0] wdat;
        logic [63:0] rdat;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   rdy_cfg = 0;
    int   dly_cfg = 0;
    bit   spur_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: works byte by byte on the architectural meaning of the access.
    function automatic void model(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wd,
                                  input logic [63:0] rd, output exp_t e, output req_t r,
                                  output bit has_req);
        int nb  = 1 << sz;
        int off = int'(addr[2:0]);
        logic [63:0] v = 64'd0;
        has_req = 1'b0;
        e.lat = -1;
        e.acc = 0;
        r.addr = 32'd0; r.wen = 1'b0; r.strb = 8'd0; r.wdat = 64'd0; r.rdat = rd;
        if (op != 2'd1 && op != 2'd2) begin
            e.res = addr; e.mis = 1'b0; e.bsy = 1'b0;
        end else if (off % nb != 0) begin
            e.res = 64'd0; e.mis = 1'b1; e.bsy = 1'b1;
        end else begin
            has_req = 1'b1;
            e.mis = 1'b0; e.bsy = 1'b1;
            r.addr = addr[31:0] - 32'(off);
            r.wen  = (op == 2'd2);
            if (op == 2'd2) begin
                for (int i = 0; i < nb; i++) r.strb[off + i] = 1'b1;
                for (int i = 0; i < 8 - off; i++) r.wdat[8*(off+i) +: 8] = wd[8*i +: 8];
                e.res = 64'd0;
            end else begin
                for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
                if (!uns && nb < 8 && v[8*nb-1])
                    for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.res = v;
            end
        end
    endfunction

    // Called at posedge+1 with valid_i low; returns at posedge+1 of the next cycle.
    task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input int lat, input bit ovr, input logic [63:0] ovr_val);
        exp_t e;
        req_t r;
        bit   has_req;
        int   n = 0;
        while (busy_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_o) begin
            checks++; errors++;
            $display("FAIL issue_timeout: busy_o still %b after %0d cycles", busy_o, n);
        end
        model(op, sz, uns, addr, wd, rd, e, r, has_req);
        if (ovr) e.res = ovr_val;
        e.lat = lat;
        e.acc = cyc;
        exp_q.push_back(e);
        if (has_req) req_q.push_back(r);
        mem_op_i = op; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per done_o pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_o) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: result %h misalign %b", result_o, misalign_o);
            end else begin
                e = exp_q.pop_front();
                chk("result", result_o, e.res);
                chk("misalign", 64'(misalign_o), 64'(e.mis));
                chk("busy_at_done", 64'(busy_o), 64'(e.bsy));
                if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    // Memory responder: ready stalls, response delay, stray responses outside WAIT.
    initial begin
        bit          in_req = 1'b0;
        bit          pending = 1'b0;
        int          stall_left = 0;
        int          dly_left = 0;
        logic [63:0] cur_rd = 64'd0;
        req_t        r;
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_rdata_i = 64'd0;
        forever begin
            @(posedge clk); #1;
            req_ready_i  = 1'b0;
            resp_valid_i = 1'b0;
            resp_rdata_i = {$urandom, $urandom};
            if (pending) begin
                if (dly_left == 0) begin
                    resp_valid_i = 1'b1;
                    resp_rdata_i = cur_rd;
                    pending = 1'b0;
                end else begin
                    dly_left--;
                end
            end else if (req_valid_o) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    stall_left = (rdy_cfg >= 0) ? rdy_cfg : int'($urandom_range(0, 3));
                end
                if (stall_left > 0) stall_left--;
                else req_ready_i = 1'b1;
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                resp_valid_i = 1'b1;
            end
            @(negedge clk);
            if (!rst && req_valid_o) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_request: addr %h wen %b", req_addr_o, req_wen_o);
                end else begin
                    chk("req_addr", 64'(req_addr_o), 64'(req_q[0].addr));
                    chk("req_wen", 64'(req_wen_o), 64'(req_q[0].wen));
                    chk("req_wstrb", 64'(req_wstrb_o), 64'(req_q[0].strb));
                    chk("req_wdata", req_wdata_o, req_q[0].wdat);
                    if (req_ready_i) begin
                        r = req_q.pop_front();
                        cur_rd = r.rdat;
                        pending = 1'b1;
                        in_req = 1'b0;
                        dly_left = (dly_cfg >= 0) ? dly_cfg : int'($urandom_range(0, 3));
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_req_valid"}, 64'(req_valid_o), 64'd0);
        chk({tag, "_result"}, result_o, 64'd0);
        chk({tag, "_misalign"}, 64'(misalign_o), 64'd0);
        chk({tag, "_req_addr"}, 64'(req_addr_o), 64'd0);
        chk({tag, "_req_wen"}, 64'(req_wen_o), 64'd0);
        chk({tag, "_req_wstrb"}, 64'(req_wstrb_o), 64'd0);
        chk({tag, "_req_wdata"}, req_wdata_o, 64'd0);
    endtask

    initial begin
        logic [1:0]  op, sz;
        logic [63:0] a;
        int          n;
        rst = 1'b1; valid_i = 1'b0; mem_op_i = 2'd0; size_i = 2'd0;
        unsigned_i = 1'b0; addr_i = 64'd0; wdata_i = 64'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        rdy_cfg = 0; dly_cfg = 0;
        issue(2'b00, 2'd0, 1'b0, 64'h1234, 64'd0, 64'd0, 0, 1'b1, 64'h1234);
        issue(2'b11, 2'd3, 1'b0, 64'hDEAD_BEEF_0000_0007, 64'd0, 64'd0, 0, 1'b1,
              64'hDEAD_BEEF_0000_0007);
        issue(2'b01, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 3, 1'b1,
              64'hFFFF_FFFF_FFFF_FF80);
        issue(2'b01, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 3, 1'b1,
              64'h80);
        issue(2'b10, 2'd1, 1'b0, 64'h8000_0006, 64'hABCD, 64'h1111, 3, 1'b1, 64'd0);
        issue(2'b01, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 1, 1'b1, 64'd0);

        rdy_cfg = 3; dly_cfg = 1;
        issue(2'b01, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 7, 1'b1,
              64'h0123_4567_89AB_CDEF);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("stall_busy", 64'(busy_o), 64'd1);
            @(posedge clk); #1;
        end

        // Abort an access in WAIT; the late response must be ignored.
        rdy_cfg = 0; dly_cfg = 2;
        issue(2'b01, 2'd3, 1'b0, 64'h8000_0020, 64'd0, 64'hFEED_FACE_CAFE_F00D, -1, 1'b0, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outputs("abort");
            @(posedge clk); #1;
        end

        rdy_cfg = -1; dly_cfg = -1; spur_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
            issue(op, sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                  {$urandom, $urandom}, -1, 1'b0, 64'd0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results and %0d requests outstanding",
                     exp_q.size(), req_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
